// File: rtl/register_bank_if.sv
// register_bank_if: read ports, two-slot writeback request and PC signals between
// decode/execute (master) and the register bank (slave).
interface register_bank_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        Rn, Rm, Rs;
    logic [DATA_W-1:0] rn_data, rm_data, rs_data;
    logic              wb_valid, wb_ready;
    logic              wb_en0, wb_en1;
    logic [3:0]        wb_addr0, wb_addr1;
    logic [DATA_W-1:0] wb_data0, wb_data1;
    logic              pc_inc;
    logic [DATA_W-1:0] pc;
    logic              busy;

    modport master (
        output Rn, Rm, Rs, wb_valid, wb_en0, wb_addr0, wb_data0, wb_en1, wb_addr1, wb_data1, pc_inc,
        input  rn_data, rm_data, rs_data, wb_ready, pc, busy
    );

    modport slave (
        input  Rn, Rm, Rs, wb_valid, wb_en0, wb_addr0, wb_data0, wb_en1, wb_addr1, wb_data1, pc_inc,
        output rn_data, rm_data, rs_data, wb_ready, pc, busy
    );
endinterface

// File: rtl/register_bank.sv
// register_bank: ARM 16x32 register file (R15 = auto-incrementing PC), three async read ports, two-slot writeback.
// Optional REGFILE_BYPASS_EN: reads matching the pending slot return the pending data.
module register_bank #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4)
) (
    input logic clk,
    input logic rst_n,
    register_bank_if.slave bus
);
    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [DATA_W-1:0] PC_OFF = PC_STEP << 1;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [15];
    logic [DATA_W-1:0] pc_q;
    logic [3:0]        pend_addr_q;
    logic [DATA_W-1:0] pend_data_q;

    logic              accept;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_raw, wr_data;
    logic [DATA_W-1:0] view [16];

    assign accept = bus.wb_valid && state_q == IDLE;

    // A pending slot-1 commit always owns the write port; otherwise slot 0 beats slot 1.
    always_comb begin
        wr_en   = state_q == PEND || (accept && (bus.wb_en0 || bus.wb_en1));
        wr_addr = state_q == PEND ? pend_addr_q : bus.wb_en0 ? bus.wb_addr0 : bus.wb_addr1;
        wr_raw  = state_q == PEND ? pend_data_q : bus.wb_en0 ? bus.wb_data0 : bus.wb_data1;
        wr_data = wr_addr == 4'd15 ? {wr_raw[DATA_W-1:2], 2'b00} : wr_raw;
    end

    always_comb begin
        for (int i = 0; i < 15; i++) view[i] = regs_q[i];
        view[15] = pc_q + PC_OFF;
`ifdef REGFILE_BYPASS_EN
        if (state_q == PEND) view[pend_addr_q] = pend_addr_q == 4'd15 ? pend_data_q + PC_OFF : pend_data_q;
`endif
    end

    assign bus.rn_data  = view[bus.Rn];
    assign bus.rm_data  = view[bus.Rm];
    assign bus.rs_data  = view[bus.Rs];
    assign bus.pc       = pc_q;
    assign bus.wb_ready = state_q == IDLE;
    assign bus.busy     = state_q == PEND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
        end else begin
            if (wr_en && wr_addr == 4'd15) pc_q <= wr_data;
            else if (bus.pc_inc) pc_q <= pc_q + PC_STEP;
            if (wr_en && wr_addr != 4'd15) regs_q[wr_addr] <= wr_data;
            if (state_q == PEND) begin
                state_q <= IDLE;
            end else if (accept && bus.wb_en0 && bus.wb_en1) begin
                state_q     <= PEND;
                pend_addr_q <= bus.wb_addr1;
                pend_data_q <= bus.wb_addr1 == 4'd15 ? {bus.wb_data1[DATA_W-1:2], 2'b00} : bus.wb_data1;
            end
        end
    end
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed scenarios plus randomized traffic checked against a
// behavioural model of the register bank (array of 16 values plus a next-cycle write slot).
module tb_register_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    register_bank_if #(.DATA_W(32)) bus ();

    register_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #20 clk = ~clk;

    logic [31:0] mem [16];
    bit          m_pend;
    logic [3:0]  p_addr;
    logic [31:0] p_data;

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (m_pend && a == p_addr) return a == 4'd15 ? (p_data & ~32'h3) + 32'd8 : p_data;
`endif
        return a == 4'd15 ? mem[15] + 32'd8 : mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mem[i] = 32'h0;
        mem[15] = 32'h0;
        m_pend = 1'b0;
        p_addr = 4'h0;
        p_data = 32'h0;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 1'b0;
        bus.wb_en0 = 1'b0;
        bus.wb_en1 = 1'b0;
        bus.wb_addr0 = 4'h0;
        bus.wb_addr1 = 4'h0;
        bus.wb_data0 = 32'h0;
        bus.wb_data1 = 32'h0;
        bus.pc_inc = 1'b0;
    endtask

    task automatic request(input bit e0, input logic [3:0] a0, input logic [31:0] d0,
                           input bit e1, input logic [3:0] a1, input logic [31:0] d1, input bit inc);
        bus.wb_valid = 1'b1;
        bus.wb_en0 = e0;
        bus.wb_addr0 = a0;
        bus.wb_data0 = d0;
        bus.wb_en1 = e1;
        bus.wb_addr1 = a1;
        bus.wb_data1 = d1;
        bus.pc_inc = inc;
    endtask

    // One clock edge; the model applies the architectural effect of the inputs seen at that edge.
    task automatic tick();
        bit          w;
        logic [3:0]  a;
        logic [31:0] d;
        bit          np;
        @(posedge clk);
        w = 1'b0;
        a = 4'h0;
        d = 32'h0;
        np = 1'b0;
        if (m_pend) begin
            w = 1'b1; a = p_addr; d = p_data;
        end else if (bus.wb_valid) begin
            if (bus.wb_en0) begin
                w = 1'b1; a = bus.wb_addr0; d = bus.wb_data0;
            end
            if (bus.wb_en0 && bus.wb_en1) begin
                np = 1'b1; p_addr = bus.wb_addr1; p_data = bus.wb_data1;
            end else if (bus.wb_en1) begin
                w = 1'b1; a = bus.wb_addr1; d = bus.wb_data1;
            end
        end
        if (w && a == 4'd15) mem[15] = d & ~32'h3;
        else begin
            if (w) mem[a] = d;
            if (bus.pc_inc) mem[15] = mem[15] + 32'd4;
        end
        m_pend = np;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.Rn = 4'h0; bus.Rm = 4'h0; bus.Rs = 4'h0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.Rn = 4'(i);
            #1;
            vectors++;
            if (bus.rn_data !== (i == 15 ? 32'h8 : 32'h0)) begin
                errors++;
                $display("FAIL reset_read r%0d: got %h want %h", i, bus.rn_data, i == 15 ? 32'h8 : 32'h0);
            end
        end
        vectors++;
        if (bus.pc !== 32'h0 || bus.wb_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ready=%b busy=%b want pc=0 ready=1 busy=0", bus.pc, bus.wb_ready, bus.busy);
        end
        // Go into PEND, then reset asynchronously mid-cycle: the pending R5 must never land.
        request(1'b1, 4'd4, 32'hAAAA_0004, 1'b1, 4'd5, 32'h5555_0005, 1'b0);
        tick();
        idle_inputs();
        vectors++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pend_entry: busy=%b want 1", bus.busy);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        bus.Rn = 4'd4; bus.Rm = 4'd5; bus.Rs = 4'd15;
        #1;
        vectors++;
        if (bus.rn_data !== 32'h0 || bus.rm_data !== 32'h0 || bus.rs_data !== 32'h8 ||
            bus.wb_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_pend: r4=%h r5=%h r15=%h ready=%b busy=%b pc=%h want 0 0 8 1 0 0",
                     bus.rn_data, bus.rm_data, bus.rs_data, bus.wb_ready, bus.busy, bus.pc);
        end
        #2 rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.rm_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_discard: r5=%h want 0", bus.rm_data);
        end
    endtask

    task automatic test_single_write();
        request(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0, 1'b0);
        bus.Rn = 4'd3;
        #1;
        vectors++;
        if (bus.rn_data !== 32'h0) begin
            errors++;
            $display("FAIL single_before: r3=%h want 0", bus.rn_data);
        end
        tick();
        idle_inputs();
        vectors++;
        if (bus.rn_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: r3=%h want deadbeef", bus.rn_data);
        end
        // slot 1 alone writes on the accept edge too
        request(1'b0, 4'd0, 32'h0, 1'b1, 4'd10, 32'h1234_5678, 1'b0);
        tick();
        idle_inputs();
        bus.Rm = 4'd10;
        #1;
        vectors++;
        if (bus.rm_data !== 32'h1234_5678 || bus.wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL slot1_only: r10=%h ready=%b want 12345678 1", bus.rm_data, bus.wb_ready);
        end
    endtask

    task automatic test_dual_write();
        request(1'b1, 4'd4, 32'h11, 1'b1, 4'd5, 32'h22, 1'b0);
        tick();
        idle_inputs();
        bus.Rn = 4'd4; bus.Rm = 4'd5;
        #1;
        vectors++;
        if (bus.rn_data !== 32'h11 || bus.wb_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL dual_first: r4=%h ready=%b busy=%b want 11 0 1", bus.rn_data, bus.wb_ready, bus.busy);
        end
        vectors++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rm_data !== 32'h22) begin
            errors++;
            $display("FAIL dual_bypass: r5=%h want 22", bus.rm_data);
        end
`else
        if (bus.rm_data !== 32'h0) begin
            errors++;
            $display("FAIL dual_pend_hidden: r5=%h want 0", bus.rm_data);
        end
`endif
        tick();
        vectors++;
        if (bus.rm_data !== 32'h22 || bus.wb_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL dual_second: r5=%h ready=%b busy=%b want 22 1 0", bus.rm_data, bus.wb_ready, bus.busy);
        end
    endtask

    task automatic test_same_address();
        request(1'b1, 4'd6, 32'h1, 1'b1, 4'd6, 32'h2, 1'b0);
        tick();
        idle_inputs();
        bus.Rs = 4'd6;
        #1;
        vectors++;
        if (bus.rs_data !== exp_rd(4'd6)) begin
            errors++;
            $display("FAIL same_addr_pend: r6=%h want %h", bus.rs_data, exp_rd(4'd6));
        end
        tick();
        vectors++;
        if (bus.rs_data !== 32'h2) begin
            errors++;
            $display("FAIL same_addr_final: r6=%h want 2", bus.rs_data);
        end
    endtask

    task automatic test_pc();
        request(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'h0, 1'b1);
        tick();
        idle_inputs();
        bus.Rn = 4'd15;
        #1;
        vectors++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.rn_data !== 32'h4) begin
            errors++;
            $display("FAIL pc_load: pc=%h r15=%h want fffffffc 00000004", bus.pc, bus.rn_data);
        end
        bus.pc_inc = 1'b1;
        tick();
        bus.pc_inc = 1'b0;
        vectors++;
        if (bus.pc !== 32'h0 || bus.rn_data !== 32'h8) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h r15=%h want 0 8", bus.pc, bus.rn_data);
        end
        request(1'b1, 4'd15, 32'h103, 1'b0, 4'd0, 32'h0, 1'b1);
        tick();
        idle_inputs();
        vectors++;
        if (bus.pc !== 32'h100 || bus.rn_data !== 32'h108) begin
            errors++;
            $display("FAIL pc_commit_override: pc=%h r15=%h want 100 108", bus.pc, bus.rn_data);
        end
        // pending R15 commit in PEND also overrides pc_inc
        request(1'b1, 4'd1, 32'h77, 1'b1, 4'd15, 32'h202, 1'b1);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        vectors++;
        if (bus.pc !== 32'h104 || bus.rn_data !== exp_rd(4'd15)) begin
            errors++;
            $display("FAIL pc_pend_inc: pc=%h r15=%h want 104 %h", bus.pc, bus.rn_data, exp_rd(4'd15));
        end
        tick();
        idle_inputs();
        vectors++;
        if (bus.pc !== 32'h200) begin
            errors++;
            $display("FAIL pc_pend_commit: pc=%h want 200", bus.pc);
        end
    endtask

    task automatic test_back_pressure();
        bit accepted;
        request(1'b1, 4'd7, 32'h7, 1'b1, 4'd8, 32'h8, 1'b0);
        tick();
        request(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'h0, 1'b0);
        bus.Rn = 4'd9; bus.Rm = 4'd8;
        #1;
        vectors++;
        if (bus.wb_ready !== 1'b0 || bus.rn_data !== 32'h0) begin
            errors++;
            $display("FAIL bp_held: ready=%b r9=%h want 0 0", bus.wb_ready, bus.rn_data);
        end
        accepted = 1'b0;
        for (int c = 0; c < 5 && !accepted; c++) begin
            accepted = bus.wb_ready;
            tick();
        end
        vectors++;
        if (!accepted) begin
            errors++;
            $display("FAIL bp_timeout: ready never returned within 5 cycles");
        end
        request(1'b1, 4'd9, 32'h5, 1'b0, 4'd0, 32'h0, 1'b0);
        vectors++;
        if (bus.rn_data !== 32'h99 || bus.rm_data !== 32'h8) begin
            errors++;
            $display("FAIL bp_commit: r9=%h r8=%h want 99 8", bus.rn_data, bus.rm_data);
        end
        tick();
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (bus.rn_data !== 32'h5) begin
            errors++;
            $display("FAIL bp_once: r9=%h want 5", bus.rn_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            request(1'b1, 4'(i), 32'hB0B0_0000 + 32'(i), 1'b0, 4'd0, 32'h0, 1'b0);
            tick();
            vectors++;
            if (bus.wb_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: cycle %0d ready=%b want 1", i, bus.wb_ready);
            end
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            bus.Rs = 4'(i);
            #1;
            vectors++;
            if (bus.rs_data !== 32'hB0B0_0000 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_data: r%0d=%h want %h", i, bus.rs_data, 32'hB0B0_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.Rn = 4'($urandom_range(0, 15));
            bus.Rm = 4'($urandom_range(0, 15));
            bus.Rs = 4'($urandom_range(0, 15));
            #1;
            vectors++;
            if (bus.rn_data !== exp_rd(bus.Rn) || bus.rm_data !== exp_rd(bus.Rm) || bus.rs_data !== exp_rd(bus.Rs) ||
                bus.pc !== mem[15] || bus.wb_ready !== !m_pend || bus.busy !== m_pend) begin
                errors++;
                $display("FAIL random[%0d]: rn(%0d)=%h/%h rm(%0d)=%h/%h rs(%0d)=%h/%h pc=%h/%h ready=%b/%b busy=%b/%b",
                         n, bus.Rn, bus.rn_data, exp_rd(bus.Rn), bus.Rm, bus.rm_data, exp_rd(bus.Rm),
                         bus.Rs, bus.rs_data, exp_rd(bus.Rs), bus.pc, mem[15], bus.wb_ready, !m_pend, bus.busy, m_pend);
            end
            bus.wb_valid = $urandom_range(0, 3) != 0;
            bus.wb_en0 = $urandom_range(0, 1) == 1;
            bus.wb_en1 = $urandom_range(0, 2) == 0;
            bus.wb_addr0 = 4'($urandom_range(0, 15));
            bus.wb_addr1 = $urandom_range(0, 3) == 0 ? bus.wb_addr0 : 4'($urandom_range(0, 15));
            bus.wb_data0 = $urandom;
            bus.wb_data1 = $urandom;
            bus.pc_inc = $urandom_range(0, 1) == 1;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        bus.Rn = 4'h0; bus.Rm = 4'h0; bus.Rs = 4'h0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_dual_write();
        test_same_address();
        test_pc();
        test_back_pressure();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
